c3lib_sync_filt_nbit: RTL
=========================

C3LIB_SYNC_FILT_NBIT -- requirements
Module: c3lib_sync_filt_nbit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: number of independent channels, legal range 1-32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: flop stages per channel before the filter, legal range 2-4.
REQ-003 The block SHALL have parameter RESET_VAL, WIDTH bits, default all-0: per-channel reset value of the sync chain and data_out.
REQ-004 The block SHALL have parameter FILT_CYCLES, default 4: consecutive cycles a new synced value must persist before acceptance, legal range 1-255.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port data_in, input, WIDTH bits: asynchronous level inputs.
REQ-008 The block SHALL have port data_out, output, WIDTH bits: synchronized, filtered levels.
REQ-009 The block SHALL have port rise_pulse, output, WIDTH bits: one-cycle pulse on each data_out 0->1 transition.
REQ-010 The block SHALL have port fall_pulse, output, WIDTH bits: one-cycle pulse on each data_out 1->0 transition.
REQ-011 The block SHALL have port busy, output, WIDTH bits: channel has a candidate value under qualification.

Function
REQ-012 Each channel SHALL pass data_in[i] through SYNC_STAGES flops; the last stage is the synced value s[i].
REQ-013 Each channel SHALL hold a counter cnt[i] of width clog2(FILT_CYCLES+1).
REQ-014 While s[i] equals data_out[i], cnt[i] SHALL load 0 on each clk edge; a mismatch lasting fewer than FILT_CYCLES cycles is rejected.
REQ-015 While s[i] differs from data_out[i] and cnt[i] is below FILT_CYCLES-1, cnt[i] SHALL increment.
REQ-016 On an edge where s[i] differs and cnt[i] equals FILT_CYCLES-1, data_out[i] SHALL load s[i] and cnt[i] SHALL load 0.
REQ-017 With FILT_CYCLES=1, data_out[i] SHALL update on the first edge where s[i] differs.
REQ-018 A data_in[i] level held stable SHALL appear on data_out[i] exactly SYNC_STAGES+FILT_CYCLES clk edges after it is first sampled.
REQ-019 rise_pulse[i] and fall_pulse[i] SHALL be registered and asserted in the same cycle data_out[i] first shows the new value, for exactly one cycle.
REQ-020 rise_pulse[i] and fall_pulse[i] SHALL never be asserted together.
REQ-021 busy[i] SHALL be combinational, equal to (cnt[i] != 0).
REQ-022 Channels SHALL be fully independent; simultaneous transitions on any set of channels SHALL each follow REQ-014 to REQ-019.
REQ-023 The counter SHALL never exceed FILT_CYCLES-1 and SHALL never wrap.

Reset
REQ-024 When rst is high at a clk edge, all sync stages and data_out SHALL load RESET_VAL, cnt SHALL load 0, and rise_pulse and fall_pulse SHALL load 0.
REQ-025 Reset SHALL take priority over all other updates, including an edge that would otherwise complete qualification.
REQ-026 Reset SHALL never generate a rise or fall pulse, even when data_out changes value because of reset.
REQ-027 In the first cycle after rst deasserts, busy SHALL be 0 and data_out SHALL equal RESET_VAL.

Structure
REQ-028 Package c3lib_sync_pkg SHALL hold the parameter limits (SYNC_STAGES_MIN=2, SYNC_STAGES_MAX=4, FILT_CYCLES_MAX=255) and a function computing the counter width.
REQ-029 Per-channel logic SHALL live in sub-module c3lib_sync_filt_chan, instantiated WIDTH times by a generate loop.
REQ-030 Sync flops SHALL be grouped as a distinct synchronizer structure for CDC-tool recognition.
REQ-031 Out-of-range parameters SHALL cause an elaboration-time error.

Verification
REQ-032 Reset and hold: WIDTH=4, RESET_VAL=4'b1010, rst high for 3 cycles then low, data_in=4'b1010 -> data_out=4'b1010, busy=0, no pulses.
REQ-033 Latency: SYNC_STAGES=2, FILT_CYCLES=4, data_in[0] goes 0->1 and holds -> data_out[0] rises 6 edges later, rise_pulse[0] high exactly 1 cycle.
REQ-034 Glitch rejection: FILT_CYCLES=4, data_in[1] high for 3 cycles then low -> data_out[1] stays 0, busy[1] high for 3 cycles then 0, no pulses.
REQ-035 Mid-qualification reset: rst asserted at cnt=2 -> cnt=0, data_out=RESET_VAL, no pulse; after release, qualification restarts from 0.
REQ-036 Multi-channel: data_in 4'b0000->4'b1111 in one cycle, then 4'b0101 after 10 cycles -> all rise_pulse bits fire together; later fall_pulse[3] and fall_pulse[1] fire together.
REQ-037 FILT_CYCLES=1, SYNC_STAGES=3: a 1-cycle-wide data_in pulse aligned to clk -> data_out pulses 1 cycle, 4 edges later.

Source files
------------

// File: rtl/c3lib_sync_pkg.sv
// Shared limits and helpers for the multi-channel synchronizer/glitch filter.
package c3lib_sync_pkg;

   localparam int WIDTH_MIN       = 1;
   localparam int WIDTH_MAX       = 32;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int FILT_CYCLES_MIN = 1;
   localparam int FILT_CYCLES_MAX = 255;

   // Width needed to hold 0..filt_cycles; the counter itself tops out at filt_cycles-1.
   function automatic int cnt_width(input int filt_cycles);
      return $clog2(filt_cycles + 1);
   endfunction

endpackage

// File: rtl/c3lib_sync_filt_chan.sv
// One channel: synchronizer chain followed by a persistence filter with edge pulses.
module c3lib_sync_filt_chan
   import c3lib_sync_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_CYCLES = 4,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic data_in,
   output logic data_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   localparam int             CW     = cnt_width(FILT_CYCLES);
   localparam logic [CW-1:0]  CNT_TC = CW'(FILT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   data_q, data_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // Synchronizer kept in its own process so CDC tools see a clean flop chain.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= {SYNC_STAGES{RESET_VAL}};
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
   end

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (synced == data_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TC) begin
         data_d = synced;
         cnt_d  = '0;
         rise_d = synced;
         fall_d = ~synced;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         data_q <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         data_q <= data_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign data_out   = data_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = (cnt_q != '0);

endmodule

// File: rtl/c3lib_sync_filt_nbit.sv
// WIDTH independent synchronize-and-filter channels for asynchronous level inputs.
module c3lib_sync_filt_nbit
   import c3lib_sync_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0,
   parameter int               FILT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] busy
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("c3lib_sync_filt_nbit: WIDTH %0d out of range", WIDTH);
   end
   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("c3lib_sync_filt_nbit: SYNC_STAGES %0d out of range", SYNC_STAGES);
   end
   if (FILT_CYCLES < FILT_CYCLES_MIN || FILT_CYCLES > FILT_CYCLES_MAX) begin : g_bad_filt
      $error("c3lib_sync_filt_nbit: FILT_CYCLES %0d out of range", FILT_CYCLES);
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      c3lib_sync_filt_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_CYCLES (FILT_CYCLES),
         .RESET_VAL   (RESET_VAL[i])
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .data_in    (data_in[i]),
         .data_out   (data_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i]),
         .busy       (busy[i])
      );
   end

endmodule
